// File: rtl/config_pkg.sv
// Floating-point configuration shared by the FPU blocks.
// Field widths of the Zfa round-to-integer operand bundle.
package config_pkg;

    localparam int FLEN    = 64;
    localparam int NE      = 11;
    localparam int NF      = 52;
    localparam int FMTBITS = 2;
    localparam int LOGFLEN = $clog2(FLEN);
    localparam int OPW     = 1 + NE + (NF + 1) + 2 + FMTBITS + 3 + LOGFLEN + 1;

endpackage

// File: rtl/fround_sched_if.sv
// Request/response bundle of the shared FRound scheduler.
// slave = scheduler side, master = requesters/datapath/consumer side.
interface fround_sched_if #(
    parameter int NREQ = 2,
    parameter int TAGW = 5
);
    import config_pkg::*;

    localparam int IW = $clog2(NREQ);

    logic                 Flush;
    logic [NREQ-1:0]      ReqValid;
    logic [NREQ-1:0]      ReqReady;
    logic [NREQ*OPW-1:0]  ReqOp;
    logic [NREQ*TAGW-1:0] ReqTag;
    logic [OPW-1:0]       RndOp;
    logic [FLEN-1:0]      RndResult;
    logic                 RndNV;
    logic                 RndNX;
    logic                 RspValid;
    logic                 RspReady;
    logic [IW-1:0]        RspId;
    logic [TAGW-1:0]      RspTag;
    logic [FLEN-1:0]      RspResult;
    logic                 RspNV;
    logic                 RspNX;
    logic [NREQ-1:0]      FlagClr;
    logic [NREQ-1:0]      AccNV;
    logic [NREQ-1:0]      AccNX;

    modport slave (
        input  Flush, ReqValid, ReqOp, ReqTag,
        input  RndResult, RndNV, RndNX,
        input  RspReady, FlagClr,
        output ReqReady, RndOp,
        output RspValid, RspId, RspTag, RspResult, RspNV, RspNX,
        output AccNV, AccNX
    );

    modport master (
        output Flush, ReqValid, ReqOp, ReqTag,
        output RndResult, RndNV, RndNX,
        output RspReady, FlagClr,
        input  ReqReady, RndOp,
        input  RspValid, RspId, RspTag, RspResult, RspNV, RspNX,
        input  AccNV, AccNX
    );

endinterface

// File: rtl/fround_sched.sv
// Round-robin scheduler sharing one Zfa FRound datapath.
// S1 issue register feeds the datapath, S2 holds the response.
module fround_sched #(
    parameter int NREQ = 2,
    parameter int TAGW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    fround_sched_if.slave bus
);
    import config_pkg::*;

    localparam int IW = $clog2(NREQ);

    logic            s1v, s2v;
    logic [IW-1:0]   s1id, s2id, ptr;
    logic [OPW-1:0]  s1op;
    logic [TAGW-1:0] s1tag, s2tag;
    logic [FLEN-1:0] s2res;
    logic            s2nv, s2nx;
    logic [NREQ-1:0] accnv, accnx;

    logic [NREQ-1:0] gnt, rdy;
    logic [IW-1:0]   gid, pnext;
    logic            gvld;
    logic [OPW-1:0]  selop;
    logic [TAGW-1:0] seltag;
    logic            s2adv, s1adv, s1free, take, hs;

    assign s2adv  = ~s2v | bus.RspReady;
    assign s1adv  = s1v & s2adv;
    assign s1free = ~s1v | s1adv;
    assign rdy    = gnt & {NREQ{s1free & ~bus.Flush & reset_n}};
    assign take   = |rdy;
    assign hs     = s2v & bus.RspReady & ~bus.Flush;
    assign pnext  = (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;

    // First valid requester at or after the pointer, wrapping at NREQ
    always_comb begin
        int idx;
        gnt  = '0;
        gid  = '0;
        gvld = 1'b0;
        idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gvld && bus.ReqValid[IW'(idx)]) begin
                gvld = 1'b1;
                gid  = IW'(idx);
            end
        end
        if (gvld) gnt[gid] = 1'b1;
    end

    // Operand and tag of the granted requester
    always_comb begin
        selop  = '0;
        seltag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                selop  = bus.ReqOp[i*OPW +: OPW];
                seltag = bus.ReqTag[i*TAGW +: TAGW];
            end
        end
    end

    // Issue and result stages plus round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1v   <= 1'b0;
            s1id  <= '0;
            s1op  <= '0;
            s1tag <= '0;
            s2v   <= 1'b0;
            s2id  <= '0;
            s2tag <= '0;
            s2res <= '0;
            s2nv  <= 1'b0;
            s2nx  <= 1'b0;
            ptr   <= '0;
        end else if (bus.Flush) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
        end else begin
            if (take) begin
                s1v   <= 1'b1;
                s1id  <= gid;
                s1op  <= selop;
                s1tag <= seltag;
                ptr   <= pnext;
            end else if (s1adv) begin
                s1v <= 1'b0;
            end
            if (s1adv) begin
                s2v   <= 1'b1;
                s2id  <= s1id;
                s2tag <= s1tag;
                s2res <= bus.RndResult;
                s2nv  <= bus.RndNV;
                s2nx  <= bus.RndNX;
            end else if (hs) begin
                s2v <= 1'b0;
            end
        end
    end

    // Sticky flags per requester; an explicit clear beats a same-cycle set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accnv <= '0;
            accnx <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.FlagClr[i]) begin
                    accnv[i] <= 1'b0;
                    accnx[i] <= 1'b0;
                end else if (hs && s2id == IW'(i)) begin
                    accnv[i] <= accnv[i] | s2nv;
                    accnx[i] <= accnx[i] | s2nx;
                end
            end
        end
    end

    assign bus.ReqReady  = rdy;
    assign bus.RndOp     = s1op;
    assign bus.RspValid  = s2v;
    assign bus.RspId     = s2id;
    assign bus.RspTag    = s2tag;
    assign bus.RspResult = s2res;
    assign bus.RspNV     = s2nv;
    assign bus.RspNX     = s2nx;
    assign bus.AccNV     = accnv;
    assign bus.AccNX     = accnx;

endmodule

// File: tb/tb_fround_sched.sv
// Bench for fround_sched: cycle table plus scoreboard of responses
// and a model of the sticky flag accumulators.
module tb_fround_sched;
    import config_pkg::*;

    localparam int NREQ = 2;
    localparam int TAGW = 5;
    localparam int IW   = 1;
    localparam int NV   = 19;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fround_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

    fround_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FLEN-1:0] dp(input logic [OPW-1:0] op);
        return op[OPW-1 -: FLEN] ^ 64'h5a5a_0f0f_3c3c_9696;
    endfunction

    assign bus.RndResult = dp(bus.RndOp);
    assign bus.RndNV     = bus.RndOp[0];
    assign bus.RndNX     = bus.RndOp[1];

    typedef struct {
        logic [IW-1:0]   id;
        logic [TAGW-1:0] tag;
        logic [FLEN-1:0] res;
        logic            nv;
        logic            nx;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0]      rv;
        logic                 rr;
        logic [NREQ*OPW-1:0]  ops;
        logic [NREQ*TAGW-1:0] tags;
        logic [NREQ-1:0]      erdy;
        logic                 ersp;
    } vec_t;

    exp_t q[$];
    vec_t tv[NV];
    int checks = 0;
    int fails = 0;
    logic [NREQ-1:0] mnv, mnx;
    logic hs;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW-1:0] mkop(input logic nv, input logic nx);
        logic [95:0] r;
        logic [OPW-1:0] o;
        r = {$urandom(), $urandom(), $urandom()};
        o = r[OPW-1:0];
        o[1:0] = {nx, nv};
        return o;
    endfunction

    function automatic vec_t mk(input logic [NREQ-1:0] rv, input logic rr,
                                input logic [NREQ-1:0] erdy, input logic ersp);
        vec_t v;
        v.rv   = rv;
        v.rr   = rr;
        v.ops  = {mkop(1'($urandom()), 1'($urandom())),
                  mkop(1'($urandom()), 1'($urandom()))};
        v.tags = (NREQ*TAGW)'($urandom());
        v.erdy = erdy;
        v.ersp = ersp;
        return v;
    endfunction

    // Scoreboard and flag model, evaluated away from the active edge
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            mnv = '0;
            mnx = '0;
        end else begin
            chk("acc_nv", 128'(bus.AccNV), 128'(mnv));
            chk("acc_nx", 128'(bus.AccNX), 128'(mnx));
            chk("grant_onehot", 128'($onehot0(bus.ReqReady)), 128'(1));
            hs = bus.RspValid & bus.RspReady & ~bus.Flush;
            if (bus.RspValid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rsp_unexpected id=%0d tag=%0h t=%0t",
                             bus.RspId, bus.RspTag, $time);
                end else begin
                    chk("rsp_id", 128'(bus.RspId), 128'(q[0].id));
                    chk("rsp_tag", 128'(bus.RspTag), 128'(q[0].tag));
                    chk("rsp_res", 128'(bus.RspResult), 128'(q[0].res));
                    chk("rsp_nv", 128'(bus.RspNV), 128'(q[0].nv));
                    chk("rsp_nx", 128'(bus.RspNX), 128'(q[0].nx));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.FlagClr[i]) begin
                    mnv[i] = 1'b0;
                    mnx[i] = 1'b0;
                end else if (hs && q.size() != 0 && q[0].id == IW'(i)) begin
                    mnv[i] = mnv[i] | q[0].nv;
                    mnx[i] = mnx[i] | q[0].nx;
                end
            end
            if (hs && q.size() != 0) void'(q.pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ReqValid[i] && bus.ReqReady[i]) begin
                    exp_t e;
                    logic [OPW-1:0] op;
                    op    = bus.ReqOp[i*OPW +: OPW];
                    e.id  = IW'(i);
                    e.tag = bus.ReqTag[i*TAGW +: TAGW];
                    e.res = dp(op);
                    e.nv  = op[0];
                    e.nx  = op[1];
                    q.push_back(e);
                end
            end
            if (bus.Flush) q.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [OPW-1:0] o;
        bus.Flush    = 1'b0;
        bus.ReqValid = '0;
        bus.ReqOp    = '0;
        bus.ReqTag   = '0;
        bus.RspReady = 1'b1;
        bus.FlagClr  = '0;
        mnv = '0;
        mnx = '0;

        tv[0]  = mk(2'b01, 1'b1, 2'b01, 1'b0);
        tv[1]  = mk(2'b00, 1'b1, 2'b00, 1'b0);
        tv[2]  = mk(2'b10, 1'b1, 2'b10, 1'b1);
        tv[3]  = mk(2'b11, 1'b1, 2'b01, 1'b0);
        tv[4]  = mk(2'b11, 1'b1, 2'b10, 1'b1);
        tv[5]  = mk(2'b11, 1'b1, 2'b01, 1'b1);
        tv[6]  = mk(2'b11, 1'b1, 2'b10, 1'b1);
        tv[7]  = mk(2'b00, 1'b1, 2'b00, 1'b1);
        tv[8]  = mk(2'b00, 1'b1, 2'b00, 1'b1);
        tv[9]  = mk(2'b00, 1'b1, 2'b00, 1'b0);
        tv[10] = mk(2'b11, 1'b0, 2'b01, 1'b0);
        tv[11] = mk(2'b11, 1'b0, 2'b10, 1'b0);
        tv[12] = mk(2'b11, 1'b0, 2'b00, 1'b1);
        tv[13] = mk(2'b11, 1'b0, 2'b00, 1'b1);
        tv[14] = mk(2'b11, 1'b0, 2'b00, 1'b1);
        tv[15] = mk(2'b11, 1'b1, 2'b01, 1'b1);
        tv[16] = mk(2'b00, 1'b1, 2'b00, 1'b1);
        tv[17] = mk(2'b00, 1'b1, 2'b00, 1'b1);
        tv[18] = mk(2'b00, 1'b1, 2'b00, 1'b0);

        tick();
        tick();
        chk("rst_rspv", 128'(bus.RspValid), 128'(0));
        chk("rst_acc", 128'({bus.AccNV, bus.AccNX}), 128'(0));
        chk("rst_rndop", 128'(bus.RndOp), 128'(0));
        chk("rst_rsp", 128'({bus.RspId, bus.RspTag, bus.RspResult,
                             bus.RspNV, bus.RspNX}), 128'(0));
        reset_n = 1'b1;
        tick();

        for (int n = 0; n < NV; n++) begin
            bus.ReqValid = tv[n].rv;
            bus.RspReady = tv[n].rr;
            bus.ReqOp    = tv[n].ops;
            bus.ReqTag   = tv[n].tags;
            #3;
            chk($sformatf("vec%0d_rdy", n), 128'(bus.ReqReady), 128'(tv[n].erdy));
            chk($sformatf("vec%0d_rspv", n), 128'(bus.RspValid), 128'(tv[n].ersp));
            tick();
        end

        // sticky NX on requester 1: set, clear, clear coincident with set
        bus.ReqValid = '0;
        bus.RspReady = 1'b1;
        bus.FlagClr  = '1;
        tick();
        bus.FlagClr = '0;
        o = mkop(1'b0, 1'b1);
        bus.ReqOp[OPW +: OPW]    = o;
        bus.ReqTag[TAGW +: TAGW] = 5'h1a;
        bus.ReqValid = 2'b10;
        #3;
        chk("a_rdy", 128'(bus.ReqReady), 128'(2'b10));
        tick();
        bus.ReqValid = '0;
        tick();
        tick();
        chk("a_nx_set", 128'(bus.AccNX[1]), 128'(1));
        chk("a_nv_clear", 128'(bus.AccNV[1]), 128'(0));
        bus.FlagClr = 2'b10;
        tick();
        bus.FlagClr = '0;
        chk("a_nx_cleared", 128'(bus.AccNX[1]), 128'(0));
        bus.ReqValid = 2'b10;
        tick();
        bus.ReqValid = '0;
        tick();
        #2;
        chk("a_rspv", 128'(bus.RspValid), 128'(1));
        bus.FlagClr = 2'b10;
        tick();
        bus.FlagClr = '0;
        chk("a_coinc", 128'(bus.AccNX[1]), 128'(0));
        tick();
        chk("a_coinc_hold", 128'(bus.AccNX[1]), 128'(0));

        // flush with both stages full and requests pending
        bus.FlagClr = '1;
        tick();
        bus.FlagClr  = '0;
        bus.RspReady = 1'b0;
        bus.ReqOp    = {mkop(1'b1, 1'b1), mkop(1'b1, 1'b1)};
        bus.ReqValid = 2'b11;
        tick();
        tick();
        bus.Flush    = 1'b1;
        bus.RspReady = 1'b1;
        #2;
        chk("b_rdy", 128'(bus.ReqReady), 128'(0));
        chk("b_rspv_pre", 128'(bus.RspValid), 128'(1));
        tick();
        bus.Flush    = 1'b0;
        bus.ReqValid = '0;
        #1;
        chk("b_rspv", 128'(bus.RspValid), 128'(0));
        chk("b_accnv", 128'(bus.AccNV), 128'(0));
        chk("b_accnx", 128'(bus.AccNX), 128'(0));
        bus.ReqValid = 2'b11;
        #1;
        chk("b_ptr", 128'(bus.ReqReady), 128'(2'b01));
        tick();
        bus.ReqValid = '0;
        tick();
        tick();
        tick();

        // asynchronous reset in the middle of a burst
        bus.ReqOp    = {mkop(1'b1, 1'b1), mkop(1'b1, 1'b1)};
        bus.ReqValid = 2'b11;
        repeat (4) tick();
        #1;
        chk("c_acc_pre", 128'(bus.AccNV), 128'(2'b11));
        #1;
        reset_n = 1'b0;
        #1;
        chk("c_rspv", 128'(bus.RspValid), 128'(0));
        chk("c_rdy", 128'(bus.ReqReady), 128'(0));
        chk("c_acc", 128'({bus.AccNV, bus.AccNX}), 128'(0));
        bus.ReqValid = '0;
        tick();
        tick();
        reset_n = 1'b1;
        bus.ReqValid = 2'b11;
        #2;
        chk("c_ptr", 128'(bus.ReqReady), 128'(2'b01));
        tick();
        bus.ReqValid = '0;
        repeat (4) tick();
        chk("end_rspv", 128'(bus.RspValid), 128'(0));
        chk("end_queue", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
